// File: rtl/drum_spi_pkg.sv
// rtl/drum_spi_pkg.sv - shared types and constants for the drum-command SPI link
package drum_spi_pkg;
    localparam int FRAME_W     = 8;
    localparam int DRUM_CODE_W = 4;
    localparam int NUM_DRUMS   = 8;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, ACK, GAP} spi_mst_state_t;
endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - multi-stage flip-flop synchroniser for a single asynchronous bit
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/drum_spi_master.sv
// rtl/drum_spi_master.sv - SPI mode-0 master: polls done, reads one 8-bit frame, acks with load
module drum_spi_master import drum_spi_pkg::*; #(
    parameter int CLK_DIV     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   done,
    input  logic                   sdi,
    output logic                   sck,
    output logic                   sdo,
    output logic                   load,
    output logic                   busy,
    output logic                   rx_valid,
    output logic [DRUM_CODE_W-1:0] rx_code,
    output logic                   rx_error,
    output logic                   ack_tmo
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    spi_mst_state_t         state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [2:0]             bit_q, bit_d;
    logic                   bits_done_q, bits_done_d;
    logic                   tail_q, tail_d;
    logic [FRAME_W-1:0]     shreg_q, shreg_d;
    logic [TMO_W-1:0]       tmr_q, tmr_d;
    logic                   sck_q, sck_d;
    logic                   load_q, load_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [DRUM_CODE_W-1:0] rx_code_q, rx_code_d;
    logic                   rx_error_q, rx_error_d;
    logic                   ack_tmo_q, ack_tmo_d;
    logic                   done_s;
    logic                   div_last;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_done_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (done),
        .q_o   (done_s)
    );

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d     = state_q;
        div_d       = div_last ? '0 : div_q + DIV_W'(1);
        bit_d       = bit_q;
        bits_done_d = bits_done_q;
        tail_d      = tail_q;
        shreg_d     = shreg_q;
        tmr_d       = tmr_q;
        sck_d       = sck_q;
        load_d      = load_q;
        rx_valid_d  = 1'b0;
        rx_code_d   = rx_code_q;
        rx_error_d  = rx_error_q;
        ack_tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                div_d       = '0;
                sck_d       = 1'b0;
                load_d      = 1'b0;
                bit_d       = '0;
                bits_done_d = 1'b0;
                tail_d      = 1'b0;
                if (enable && done_s) state_d = SETUP;
            end
            SETUP: begin
                if (div_last) begin
                    state_d = SHIFT;
                    sck_d   = 1'b1;
                    shreg_d = {shreg_q[FRAME_W-2:0], sdi};
                end
            end
            SHIFT: begin
                // Low phase after the 8th bit lasts two half-periods (tail) before ACK.
                if (div_last) begin
                    if (sck_q) begin
                        sck_d = 1'b0;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) bits_done_d = 1'b1;
                    end else if (!bits_done_q) begin
                        sck_d   = 1'b1;
                        shreg_d = {shreg_q[FRAME_W-2:0], sdi};
                    end else if (!tail_q) begin
                        tail_d = 1'b1;
                    end else begin
                        state_d = ACK;
                        load_d  = 1'b1;
                        tmr_d   = '0;
                    end
                end
            end
            ACK: begin
                div_d = '0;
                if (!done_s) begin
                    load_d     = 1'b0;
                    rx_valid_d = 1'b1;
                    rx_code_d  = shreg_q[DRUM_CODE_W-1:0];
                    rx_error_d = |shreg_q[FRAME_W-1:DRUM_CODE_W];
                    state_d    = GAP;
                end else if (tmr_q >= TMO_LAST) begin
                    load_d    = 1'b0;
                    ack_tmo_d = 1'b1;
                    state_d   = GAP;
                end else begin
                    tmr_d = tmr_q + TMO_W'(1);
                end
            end
            GAP: begin
                if (div_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            bits_done_q <= 1'b0;
            tail_q      <= 1'b0;
            shreg_q     <= '0;
            tmr_q       <= '0;
            sck_q       <= 1'b0;
            load_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_code_q   <= '0;
            rx_error_q  <= 1'b0;
            ack_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            bits_done_q <= bits_done_d;
            tail_q      <= tail_d;
            shreg_q     <= shreg_d;
            tmr_q       <= tmr_d;
            sck_q       <= sck_d;
            load_q      <= load_d;
            rx_valid_q  <= rx_valid_d;
            rx_code_q   <= rx_code_d;
            rx_error_q  <= rx_error_d;
            ack_tmo_q   <= ack_tmo_d;
        end
    end

    assign sck      = sck_q;
    assign sdo      = 1'b0;
    assign load     = load_q;
    assign busy     = (state_q != IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_code  = rx_code_q;
    assign rx_error = rx_error_q;
    assign ack_tmo  = ack_tmo_q;
endmodule

// File: tb/tb_drum_spi_master.sv
// tb/tb_drum_spi_master.sv - randomized slave-BFM bench for drum_spi_master
module tb_drum_spi_master;
    localparam int CLK_DIV     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int ACK_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       reset, enable, done, sdi;
    logic       sck, sdo, load, busy, rx_valid, rx_error, ack_tmo;
    logic [3:0] rx_code;

    int total = 0;
    int bad   = 0;

    int         r_rises, r_loads, r_load_cyc, r_valids, r_tmos, r_busy_cyc, r_wait;
    logic [3:0] r_code;
    logic       r_err;

    drum_spi_master #(
        .CLK_DIV     (CLK_DIV),
        .SYNC_STAGES (SYNC_STAGES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .done     (done),
        .sdi      (sdi),
        .sck      (sck),
        .sdo      (sdo),
        .load     (load),
        .busy     (busy),
        .rx_valid (rx_valid),
        .rx_code  (rx_code),
        .rx_error (rx_error),
        .ack_tmo  (ack_tmo)
    );

    always #5 clk = ~clk;

    // Slave BFM: pre-drives the MSB, shifts on each sck fall, drops done dly cycles after load rises.
    task automatic run_frame(input logic [7:0] f, input int dly, input bit hold,
                             input bit rearm, input logic [7:0] fn);
        int  idx = 0, dcnt = 0, n = 0;
        bit  psck = 0, pload = 0, seen = 0, dropped = 0;
        r_rises = 0; r_loads = 0; r_load_cyc = 0; r_valids = 0; r_tmos = 0;
        r_busy_cyc = 0; r_wait = 0; r_code = 'x; r_err = 1'bx;
        sdi  = f[7];
        done = 1'b1;
        @(negedge clk);
        while (!busy && r_wait < 500) begin
            r_wait++;
            @(negedge clk);
        end
        total++;
        if (!busy) begin
            bad++;
            $display("FAIL frame_start: busy=%0b after %0d cycles, need 1", busy, r_wait);
            done = 1'b0;
            return;
        end
        while (busy && n < 2000) begin
            n++;
            r_busy_cyc++;
            if (sck && !psck) r_rises++;
            if (!sck && psck) begin
                idx++;
                if (idx < 8) sdi = f[7-idx];
            end
            if (load) r_load_cyc++;
            if (load && !pload) begin
                r_loads++;
                dcnt = dly;
                seen = 1;
            end
            if (seen && !hold && !dropped) begin
                if (dcnt == 0) begin
                    done    = 1'b0;
                    dropped = 1;
                end else dcnt--;
            end
            if (rx_valid) begin
                r_valids++;
                r_code = rx_code;
                r_err  = rx_error;
                if (rearm) begin
                    sdi  = fn[7];
                    done = 1'b1;
                end
            end
            if (ack_tmo) begin
                r_tmos++;
                done = 1'b0;
            end
            psck  = sck;
            pload = load;
            @(negedge clk);
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL frame_end: busy still 1 after %0d cycles", n);
        end
    endtask

    task automatic check_good_frame(input string nm, input logic [7:0] f, input int dly);
        total++;
        if (r_rises !== 8) begin
            bad++; $display("FAIL %s_rises: got %0d need 8", nm, r_rises);
        end
        total++;
        if (r_loads !== 1 || r_valids !== 1) begin
            bad++; $display("FAIL %s_load_valid: loads=%0d valids=%0d need 1/1", nm, r_loads, r_valids);
        end
        total++;
        if (r_code !== f[3:0] || r_err !== (f[7:4] != 4'h0)) begin
            bad++; $display("FAIL %s_data: code=%h err=%b need %h/%b", nm, r_code, r_err, f[3:0], f[7:4] != 4'h0);
        end
        total++;
        if (r_load_cyc !== SYNC_STAGES + 1 + dly) begin
            bad++; $display("FAIL %s_ack_wait: got %0d need %0d", nm, r_load_cyc, SYNC_STAGES + 1 + dly);
        end
        total++;
        if (r_busy_cyc !== CLK_DIV * 19 + r_load_cyc) begin
            bad++; $display("FAIL %s_length: got %0d need %0d", nm, r_busy_cyc, CLK_DIV * 19 + r_load_cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; done = 1'b0; sdi = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({sck, sdo, load, busy, rx_valid, rx_code, rx_error, ack_tmo} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %b need 0", {sck, sdo, load, busy, rx_valid, rx_code, rx_error, ack_tmo});
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_frame_05;
        run_frame(8'h05, 0, 0, 0, 8'h00);
        check_good_frame("f05", 8'h05, 0);
        total++;
        if (r_wait !== SYNC_STAGES) begin
            bad++; $display("FAIL f05_start_latency: got %0d need %0d", r_wait, SYNC_STAGES);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_frame_a3;
        run_frame(8'hA3, 2, 0, 0, 8'h00);
        check_good_frame("fa3", 8'hA3, 2);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout;
        run_frame(8'h5C, 0, 1, 0, 8'h00);
        total++;
        if (r_tmos !== 1 || r_valids !== 0) begin
            bad++; $display("FAIL tmo_pulses: tmo=%0d valid=%0d need 1/0", r_tmos, r_valids);
        end
        total++;
        if (r_load_cyc !== ACK_TIMEOUT) begin
            bad++; $display("FAIL tmo_ack_len: got %0d need %0d", r_load_cyc, ACK_TIMEOUT);
        end
        total++;
        if (r_busy_cyc !== CLK_DIV * 19 + ACK_TIMEOUT) begin
            bad++; $display("FAIL tmo_length: got %0d need %0d", r_busy_cyc, CLK_DIV * 19 + ACK_TIMEOUT);
        end
        total++;
        if (rx_code !== 4'h3 || rx_error !== 1'b1 || load !== 1'b0) begin
            bad++; $display("FAIL tmo_hold_outputs: code=%h err=%b load=%b need 3/1/0", rx_code, rx_error, load);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        int n = 0, rises = 0;
        bit psck = 0;
        sdi = 1'b0; done = 1'b1;
        while (rises < 4 && n < 500) begin
            @(negedge clk);
            n++;
            if (sck && !psck) rises++;
            psck = sck;
        end
        @(negedge clk);
        reset = 1'b1; done = 1'b0;
        @(negedge clk);
        total++;
        if (sck !== 1'b0 || load !== 1'b0 || busy !== 1'b0 || rx_code !== 4'h0) begin
            bad++; $display("FAIL midreset_outputs: sck=%b load=%b busy=%b code=%h rises=%0d need 0/0/0/0",
                            sck, load, busy, rx_code, rises);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        run_frame(8'h07, 1, 0, 0, 8'h00);
        check_good_frame("after_reset", 8'h07, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        run_frame(8'h05, 0, 0, 1, 8'h02);
        check_good_frame("b2b_first", 8'h05, 0);
        run_frame(8'h02, 0, 0, 0, 8'h00);
        check_good_frame("b2b_second", 8'h02, 0);
        total++;
        if (r_wait !== 0) begin
            bad++; $display("FAIL b2b_idle_len: extra idle cycles %0d need 0", r_wait);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_enable;
        int viol = 0;
        enable = 1'b0; done = 1'b1; sdi = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (sck || load || busy) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++; $display("FAIL enable_off_activity: got %0d active cycles need 0", viol);
        end
        enable = 1'b1;
        run_frame(8'h06, 0, 0, 0, 8'h00);
        check_good_frame("enable_on", 8'h06, 0);
        total++;
        if (r_wait > SYNC_STAGES + 1) begin
            bad++; $display("FAIL enable_latency: got %0d need <= %0d", r_wait, SYNC_STAGES + 1);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0] f;
        int         d;
        for (int i = 0; i < 6; i++) begin
            f = 8'($urandom_range(0, 255));
            d = $urandom_range(0, 4);
            run_frame(f, d, 0, 0, 8'h00);
            check_good_frame($sformatf("rand%0d", i), f, d);
            repeat ($urandom_range(2, 8)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_frame_05;
        test_frame_a3;
        test_timeout;
        test_reset_midframe;
        test_back_to_back;
        test_enable;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
